seq_nxm_multiplier: RTL
=======================

Name: seq_nxm_multiplier

Overview:
- Iterative shift-add N x M multiplier with a run-time signed/unsigned mode select.
- Processes one multiplier bit per clock, so one multiplier-bit step replaces the full combinational array.
- Uses a start/busy/done handshake.
- Sits beside the combinational nxm multipliers as the area-optimised option for datapaths that tolerate multi-cycle latency.

Parameters:
- N, 8, width of multiplicand A (N >= 2)
- M, 8, width of multiplier B (M >= 2); also the number of iteration cycles

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new multiply; sampled only when not busy
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
- A  input  N  multiplicand; latched on accepted start
- B  input  M  multiplier; latched on accepted start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  single-cycle pulse; P is valid from this cycle onward
- P  output  N+M  product; holds its value until the next accepted start or reset

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, P=0, counter=0, internal registers cleared.
  - Reset overrides everything, including an in-flight operation and a simultaneous start.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch A, B and signed_mode; clear the accumulator; set counter=0; go to RUN (busy=1 next cycle).
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle on multiplier bit i=counter (LSB first):
  - Partial product pp = B_lat[i] ? A_ext : 0.
    - A_ext is A_lat sign-extended to N+M bits when signed_mode=1.
    - A_ext is A_lat zero-extended otherwise.
  - i < M-1: acc += pp << i.
  - i = M-1, signed_mode=1: acc -= pp << (M-1), giving the negative MSB weight of B.
  - i = M-1, unsigned: acc += pp << (M-1).
  - All arithmetic is modulo 2^(N+M).
  - counter increments each cycle. After the iteration with counter=M-1, go to DONE.
  - Start is ignored in RUN.
  - Changes on A/B/signed_mode during RUN do not affect the result.
- DONE (exactly one cycle):
  - done=1, busy=0, P=acc.
  - If start=1 in this cycle, it is accepted exactly as in IDLE (back-to-back operation); next state is RUN.
  - Otherwise next state is IDLE.
- Latency: start accepted at edge t means busy=1 over edges t+1..t+M, and done=1 with valid P after edge t+M+1.
  - Total is M+1 cycles from accepting edge to done.
  - Throughput is one result per M+1 cycles with back-to-back starts.
- P is written only on entry to DONE. It is stable in IDLE and during the RUN of a following operation until that operation's DONE.
- Result rules:
  - Unsigned: P = A*B exactly, with no overflow, since N+M bits suffice.
  - Signed: P = $signed(A)*$signed(B) as an (N+M)-bit two's-complement value. This is exact, including the most-negative x most-negative corner case.
- done is never high in the same cycle as busy.
- busy never drops before the M iterations complete, except on reset.

Test Plan:
- Unsigned latency (N=M=8): start=1 for one cycle with A=255, B=255, signed_mode=0.
  - busy high exactly 8 cycles.
  - done pulses on the 9th edge with P=16'hFE01.
  - P holds afterwards.
- Signed corners (N=M=8, signed_mode=1):
  - -128*-128 -> P=16'h4000
  - -128*127 -> P=16'hC080
  - -1*1 -> P=16'hFFFF
  - 0*-128 -> P=16'h0000
- Back-to-back: second start asserted in the DONE cycle with A=3, B=5 unsigned.
  - First result is presented.
  - Second operation starts immediately and done pulses 9 cycles later with P=15, with no IDLE gap.
- Ignored inputs during RUN:
  - Pulse start and change A, B and signed_mode mid-RUN.
  - The original operation completes on schedule with the original product, and no extra operation is launched.
- Reset mid-operation: assert rst at iteration 4 of 8.
  - Next cycle: busy=0, done=0, P=0, state IDLE.
  - A fresh start completes correctly (e.g. 7*9=63).
- Exhaustive (N=M=4 and N=6, M=3):
  - All operand pairs in both modes against a behavioural reference ($signed product or unsigned product).
  - Zero mismatches, and every done arrives M+1 cycles after its start.

Source files
------------

// File: rtl/seq_nxm_multiplier.sv
// Iterative shift-add N x M multiplier with a start/busy/done handshake, one multiplier bit per cycle.
// Signed mode gives the multiplier MSB a negative weight, so no final correction step is needed.
module seq_nxm_multiplier #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [N-1:0]     A,
  input  logic [M-1:0]     B,
  output logic             busy,
  output logic             done,
  output logic [N+M-1:0]   P
);

  localparam int W  = N + M;
  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic [N-1:0]   r_a;
  logic [M-1:0]   r_b;
  logic           r_sm;
  logic [W-1:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_p;

  logic [W-1:0]   w_a_ext;
  logic [W-1:0]   w_pp_sh;
  logic           w_last;
  logic [W-1:0]   w_acc_nxt;

  assign w_a_ext   = r_sm ? {{M{r_a[N-1]}}, r_a} : {{M{1'b0}}, r_a};
  assign w_pp_sh   = r_b[r_cnt] ? (w_a_ext << r_cnt) : '0;
  assign w_last    = (r_cnt == CW'(M - 1));
  // The signed multiplier MSB carries weight -2^(M-1).
  assign w_acc_nxt = (w_last && r_sm) ? (r_acc - w_pp_sh) : (r_acc + w_pp_sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sm    <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_p     <= w_acc_nxt;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back throughput.
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_sm    <= signed_mode;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_p;

endmodule
